// File: rtl/dcache_sram_responder_if.sv
// dcache_interface: ready/valid request channel between a load-store unit
// (primary) and a data cache or scratchpad (secondary).
//   primary drives addr/wdata/wmask/rw/valid; secondary drives ready/rdata/rvalid.
interface dcache_interface #(
    parameter int DATA_LENGTH = 32,
    parameter int ADDR_LENGTH = 32
);
    logic [ADDR_LENGTH-1:0] addr;
    logic [DATA_LENGTH-1:0] wdata;
    logic [DATA_LENGTH-1:0] wmask;
    logic                   rw;
    logic                   valid;
    logic                   ready;
    logic [DATA_LENGTH-1:0] rdata;
    logic                   rvalid;

    modport primary (
        output addr,
        output wdata,
        output wmask,
        output rw,
        output valid,
        input  ready,
        input  rdata,
        input  rvalid
    );

    modport secondary (
        input  addr,
        input  wdata,
        input  wmask,
        input  rw,
        input  valid,
        output ready,
        output rdata,
        output rvalid
    );
endinterface

// File: rtl/dcache_sram_responder.sv
// dcache_sram_responder: word SRAM on the
// dcache_interface secondary modport.
module dcache_sram_responder #(
  parameter int    DATA_LENGTH = 32,
  parameter int    ADDR_LENGTH = 32,
  parameter int    DEPTH       = 1024,
  parameter int    LATENCY     = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic               clk,
  input  logic               rst_n,
  dcache_interface.secondary bus
);
  localparam int OFF = $clog2(DATA_LENGTH / 8);
  localparam int IDX = $clog2(DEPTH);
  localparam int CW  = $clog2(LATENCY + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [DATA_LENGTH-1:0] mem_q [DEPTH];

  logic [0:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   ready_q, ready_d;
  logic                   rvalid_q, rvalid_d;
  logic [DATA_LENGTH-1:0] rdata_q, rdata_d;
  logic [IDX-1:0]         idx_q, idx_d;

  logic [IDX-1:0]         req_idx;
  logic                   hs;
  logic                   rd_acc;
  logic                   wr_acc;
  logic                   unused_addr;

  assign req_idx     = bus.addr[OFF+IDX-1:OFF];
  assign unused_addr = ^bus.addr;

  assign hs     = bus.valid & ready_q;
  assign rd_acc = hs & ~bus.rw;
  assign wr_acc = hs & bus.rw;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    idx_d    = idx_q;

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (rd_acc) begin
          if (LATENCY == 1) begin
            rvalid_d = 1'b1;
            rdata_d  = mem_q[req_idx];
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
            ready_d = 1'b0;
            idx_d   = req_idx;
          end
        end
      end
      S_WAIT: begin
        ready_d = 1'b0;
        if (cnt_q == CNT_ONE) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          ready_d  = 1'b1;
          rvalid_d = 1'b1;
          rdata_d  = mem_q[idx_q];
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      idx_q    <= idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[req_idx] <= (mem_q[req_idx] & ~bus.wmask)
                      | (bus.wdata & bus.wmask);
    end
  end

  assign bus.ready  = ready_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
endmodule

// File: tb/tb_dcache_sram_responder.sv
// Bench for dcache_sram_responder: three instances (LATENCY 1, 2, 3)
// checked every cycle against a cycle-accurate reference of the protocol.
module tb_dcache_sram_responder;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    logic [31:0] a_addr  [3];
    logic [31:0] a_wdata [3];
    logic [31:0] a_wmask [3];
    logic        a_rw    [3];
    logic        a_valid [3];
    logic        o_ready [3];
    logic        o_rvalid[3];
    logic [31:0] o_rdata [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dcache_interface #(.DATA_LENGTH(32), .ADDR_LENGTH(32)) bus ();
        assign bus.addr    = a_addr[g];
        assign bus.wdata   = a_wdata[g];
        assign bus.wmask   = a_wmask[g];
        assign bus.rw      = a_rw[g];
        assign bus.valid   = a_valid[g];
        assign o_ready[g]  = bus.ready;
        assign o_rvalid[g] = bus.rvalid;
        assign o_rdata[g]  = bus.rdata;

        dcache_sram_responder #(
            .DATA_LENGTH(32),
            .ADDR_LENGTH(32),
            .DEPTH(1024),
            .LATENCY(g + 1),
            .INIT_FILE("")
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .bus(bus)
        );
    end

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: one outstanding read per instance with an absolute due edge.
    // A read accepted at edge e answers in the cycle after edge e+LAT-1;
    // ready is low while a response is owed and not yet delivered.
    logic [31:0] mmem   [3][1024];
    logic        m_ready [3];
    logic        m_rvalid[3];
    logic [31:0] m_rdata [3];
    bit          has_pend[3];
    longint      due     [3];
    logic [31:0] pdata   [3];
    longint      edge_n = 0;
    bit          hs_m;
    int          idx_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) begin
                m_ready[d]  = 1'b0;
                m_rvalid[d] = 1'b0;
                m_rdata[d]  = 32'h0;
                has_pend[d] = 1'b0;
            end
        end else begin
            edge_n++;
            for (int d = 0; d < 3; d++) begin
                hs_m  = a_valid[d] && m_ready[d];
                idx_m = int'((a_addr[d] >> 2) & 32'd1023);
                m_rvalid[d] = 1'b0;
                if (hs_m && a_rw[d]) begin
                    mmem[d][idx_m] = (mmem[d][idx_m] & ~a_wmask[d])
                                   | (a_wdata[d] & a_wmask[d]);
                end
                if (hs_m && !a_rw[d]) begin
                    has_pend[d] = 1'b1;
                    due[d]      = edge_n + longint'(d);
                    pdata[d]    = mmem[d][idx_m];
                end
                if (has_pend[d] && due[d] == edge_n) begin
                    m_rvalid[d] = 1'b1;
                    m_rdata[d]  = pdata[d];
                    has_pend[d] = 1'b0;
                end
                m_ready[d] = !has_pend[d];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("cyc_ready[%0d]", d), 32'(o_ready[d]), 32'(m_ready[d]));
                chk($sformatf("cyc_rvalid[%0d]", d), 32'(o_rvalid[d]), 32'(m_rvalid[d]));
                chk($sformatf("cyc_rdata[%0d]", d), o_rdata[d], m_rdata[d]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input int d);
        a_valid[d] = 1'b0;
        a_rw[d]    = 1'b0;
        a_addr[d]  = 32'h0;
        a_wdata[d] = 32'h0;
        a_wmask[d] = 32'h0;
    endtask

    task automatic req(input int d, input bit rw, input logic [31:0] ad,
                       input logic [31:0] wd, input logic [31:0] wm);
        a_valid[d] = 1'b1;
        a_rw[d]    = rw;
        a_addr[d]  = ad;
        a_wdata[d] = wd;
        a_wmask[d] = wm;
    endtask

    int rv_cnt;
    int idx_r;
    int sel;

    initial begin
        for (int d = 0; d < 3; d++) nop(d);

        // Reset: outputs clear immediately, ready rises after first edge.
        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst_ready", 32'(o_ready[1]), 32'h0);
        chk("rst_rvalid", 32'(o_rvalid[1]), 32'h0);
        chk("rst_rdata", o_rdata[1], 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        chk("rel_ready_before_edge", 32'(o_ready[1]), 32'h0);
        cyc();
        chk("rel_ready_after_edge", 32'(o_ready[1]), 32'h1);

        // LATENCY=2 write then read.
        req(1, 1'b1, 32'h10, 32'hDEADBEEF, 32'hFFFFFFFF);
        cyc();
        req(1, 1'b0, 32'h10, 32'h0, 32'h0);
        cyc();
        nop(1);
        chk("l2_ready_wait", 32'(o_ready[1]), 32'h0);
        chk("l2_rvalid_early", 32'(o_rvalid[1]), 32'h0);
        cyc();
        chk("l2_rvalid", 32'(o_rvalid[1]), 32'h1);
        chk("l2_rdata", o_rdata[1], 32'hDEADBEEF);
        chk("l2_ready_back", 32'(o_ready[1]), 32'h1);
        cyc();
        chk("l2_rvalid_pulse", 32'(o_rvalid[1]), 32'h0);
        chk("l2_rdata_hold", o_rdata[1], 32'hDEADBEEF);

        // Masked write merge.
        req(1, 1'b1, 32'h20, 32'h12345678, 32'hFFFFFFFF);
        cyc();
        req(1, 1'b1, 32'h20, 32'hAABBCCDD, 32'h0000FFFF);
        cyc();
        req(1, 1'b0, 32'h20, 32'h0, 32'h0);
        cyc();
        nop(1);
        cyc();
        chk("mask_rvalid", 32'(o_rvalid[1]), 32'h1);
        chk("mask_rdata", o_rdata[1], 32'h1234CCDD);

        // LATENCY=1 back-to-back reads.
        req(0, 1'b1, 32'h0, 32'h11111111, 32'hFFFFFFFF);
        cyc();
        req(0, 1'b1, 32'h4, 32'h22222222, 32'hFFFFFFFF);
        cyc();
        req(0, 1'b1, 32'h8, 32'h33333333, 32'hFFFFFFFF);
        cyc();
        req(0, 1'b0, 32'h0, 32'h0, 32'h0);
        cyc();
        chk("l1_rd0_rvalid", 32'(o_rvalid[0]), 32'h1);
        chk("l1_rd0_rdata", o_rdata[0], 32'h11111111);
        chk("l1_rd0_ready", 32'(o_ready[0]), 32'h1);
        req(0, 1'b0, 32'h4, 32'h0, 32'h0);
        cyc();
        chk("l1_rd1_rvalid", 32'(o_rvalid[0]), 32'h1);
        chk("l1_rd1_rdata", o_rdata[0], 32'h22222222);
        req(0, 1'b0, 32'h8, 32'h0, 32'h0);
        cyc();
        chk("l1_rd2_rvalid", 32'(o_rvalid[0]), 32'h1);
        chk("l1_rd2_rdata", o_rdata[0], 32'h33333333);
        nop(0);
        cyc();
        chk("l1_rvalid_end", 32'(o_rvalid[0]), 32'h0);

        // Alias plus valid held through ready=0.
        req(1, 1'b1, 32'h0, 32'hCAFEF00D, 32'hFFFFFFFF);
        cyc();
        req(1, 1'b0, 32'h1000, 32'h0, 32'h0);
        cyc();
        chk("alias_ready_low", 32'(o_ready[1]), 32'h0);
        cyc();
        nop(1);
        rv_cnt = int'(o_rvalid[1]);
        chk("alias_rdata", o_rdata[1], 32'hCAFEF00D);
        repeat (5) begin
            cyc();
            rv_cnt += int'(o_rvalid[1]);
        end
        chk("alias_one_rvalid", 32'(rv_cnt), 32'd1);

        // Reset mid-read on LATENCY=3.
        req(2, 1'b1, 32'h30, 32'h55AA55AA, 32'hFFFFFFFF);
        cyc();
        req(2, 1'b0, 32'h30, 32'h0, 32'h0);
        cyc();
        nop(2);
        #2 rst_n = 1'b0;
        #1;
        chk("midrd_ready", 32'(o_ready[2]), 32'h0);
        chk("midrd_rvalid", 32'(o_rvalid[2]), 32'h0);
        chk("midrd_rdata_l2", o_rdata[1], 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        rv_cnt = 0;
        repeat (6) begin
            cyc();
            rv_cnt += int'(o_rvalid[2]);
        end
        chk("midrd_no_rvalid", 32'(rv_cnt), 32'd0);
        chk("midrd_ready_back", 32'(o_ready[2]), 32'h1);
        req(2, 1'b0, 32'h30, 32'h0, 32'h0);
        cyc();
        nop(2);
        cyc();
        chk("l3_rvalid_early", 32'(o_rvalid[2]), 32'h0);
        cyc();
        chk("l3_rvalid", 32'(o_rvalid[2]), 32'h1);
        chk("l3_rdata", o_rdata[2], 32'h55AA55AA);

        // Random traffic over a preloaded window of 16 words.
        for (int i = 0; i < 16; i++) begin
            for (int d = 0; d < 3; d++) begin
                req(d, 1'b1, 32'(i) << 2, $urandom, 32'hFFFFFFFF);
            end
            cyc();
        end
        for (int n = 0; n < 2000; n++) begin
            for (int d = 0; d < 3; d++) begin
                if ($urandom_range(0, 2) != 0) begin
                    idx_r = int'($urandom_range(0, 15));
                    sel   = int'($urandom_range(0, 3));
                    req(d, 1'($urandom_range(0, 1)),
                        ($urandom & 32'hFFFFF000) | (32'(idx_r) << 2)
                            | ($urandom & 32'h3),
                        $urandom,
                        (sel == 0) ? 32'h0 :
                        (sel == 1) ? 32'hFFFFFFFF : $urandom);
                end else begin
                    nop(d);
                end
            end
            cyc();
        end
        for (int d = 0; d < 3; d++) nop(d);
        repeat (5) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
